pipe_stage_reg: RTL and testbench



---
 rtl/pipe_pkg.sv | 52 +++++
 rtl/pipe_stage_reg.sv | 145 ++++++++++++++
 tb/tb_pipe_stage_reg.sv | 178 +++++++++++++++++
 3 files changed

// File: rtl/pipe_pkg.sv
// rtl/pipe_pkg.sv - shared types and per-stage bus widths for pipeline stage registers
//
// Purpose : state encoding for pipe_stage_reg, datapath widths, and the
//           per-stage control/data bus widths and control reset values used
//           by the stage wrappers that pack/unpack their buses.
// Ports   : none (package).

package pipe_pkg;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } state_e;

    localparam int XLEN       = 32;
    localparam int REG_ADDR_W = 5;
    localparam int WB_SEL_W   = 2;

    // IF/ID: control = {valid_instr}, data = {pc, pc4, instr}
    localparam int IFID_CTRL_W = 1;
    localparam int IFID_DATA_W = 3 * XLEN;
    localparam logic [IFID_CTRL_W-1:0] IFID_CTRL_RST = '0;

    // ID/EX: control = {reg_we, wb_sel[1:0], mem_rd, mem_wr, alu_op[3:0]},
    //        data    = {pc4, rs1_data, rs2_data}
    localparam int IDEX_CTRL_W = 9;
    localparam int IDEX_DATA_W = 3 * XLEN;
    localparam logic [IDEX_CTRL_W-1:0] IDEX_CTRL_RST = '0;

    // EX/MEM: control = {reg_we, wb_sel[1:0], mem_rd, mem_wr},
    //         data    = {pc4, alu, rs2_data, rd_addr}
    localparam int EXMEM_CTRL_W = 5;
    localparam int EXMEM_DATA_W = 3 * XLEN + REG_ADDR_W;
    localparam logic [EXMEM_CTRL_W-1:0] EXMEM_CTRL_RST = '0;

    // MEM/WB: control = {reg_we, wb_sel[1:0], mem_rd},
    //         data    = {pc4, alu, mem_rd_data, rd_addr}
    localparam int MEMWB_CTRL_W = 1 + WB_SEL_W + 1;
    localparam int MEMWB_DATA_W = 3 * XLEN + REG_ADDR_W;
    localparam logic [MEMWB_CTRL_W-1:0] MEMWB_CTRL_RST = '0;

    // Number of entries held in a given state.
    function automatic logic [1:0] level_of(input state_e s);
        case (s)
            ONE:     level_of = 2'd1;
            TWO:     level_of = 2'd2;
            default: level_of = 2'd0;
        endcase
    endfunction

endpackage

// File: rtl/pipe_stage_reg.sv
// rtl/pipe_stage_reg.sv - generic valid/ready pipeline stage register with optional skid entry
//
// Purpose : holds one (SKID=0) or up to two (SKID=1) transfers between two
//           pipeline stages. Control is forced to CTRL_RST whenever the head
//           is not valid; data is never gated or cleared by flush.
// Ports   :
//   CLK        in   rising-edge clock
//   RESET_N    in   synchronous active-low reset
//   FLUSH      in   synchronous kill of all held entries
//   IN_VALID   in   upstream has a transfer
//   IN_READY   out  stage can accept (registered when SKID=1)
//   IN_CTRL    in   upstream control bus
//   IN_DATA    in   upstream payload bus
//   OUT_VALID  out  head entry valid
//   OUT_READY  in   downstream accepts
//   OUT_CTRL   out  head control, CTRL_RST when not valid
//   OUT_DATA   out  head payload
//   LEVEL      out  entries held (0..2)

module pipe_stage_reg
    import pipe_pkg::*;
#(
    parameter int                 DATA_W   = 96,
    parameter int                 CTRL_W   = 9,
    parameter logic [CTRL_W-1:0]  CTRL_RST = '0,
    parameter bit                 SKID     = 1'b1
) (
    input  logic              CLK,
    input  logic              RESET_N,
    input  logic              FLUSH,
    input  logic              IN_VALID,
    output logic              IN_READY,
    input  logic [CTRL_W-1:0] IN_CTRL,
    input  logic [DATA_W-1:0] IN_DATA,
    output logic              OUT_VALID,
    input  logic              OUT_READY,
    output logic [CTRL_W-1:0] OUT_CTRL,
    output logic [DATA_W-1:0] OUT_DATA,
    output logic [1:0]        LEVEL
);

    state_e            r_state;
    state_e            w_next_state;
    logic              r_in_ready;
    logic [CTRL_W-1:0] r_main_ctrl;
    logic [DATA_W-1:0] r_main_data;
    logic [CTRL_W-1:0] r_skid_ctrl;
    logic [DATA_W-1:0] r_skid_data;

    logic w_in_xfer;
    logic w_out_xfer;
    logic w_load_main_in;
    logic w_load_main_skid;
    logic w_load_skid;

    // State register; ready is registered from the next state so that the
    // upstream ready path does not depend on OUT_READY in skid mode.
    always_ff @(posedge CLK) begin
        if (!RESET_N) begin
            r_state    <= EMPTY;
            r_in_ready <= 1'b0;
        end else begin
            r_state    <= w_next_state;
            r_in_ready <= (w_next_state != TWO);
        end
    end

    // Next-state and entry-load decisions. FLUSH outranks any input transfer;
    // a same-cycle output transfer needs no action because the state empties.
    always_comb begin
        w_next_state     = r_state;
        w_load_main_in   = 1'b0;
        w_load_main_skid = 1'b0;
        w_load_skid      = 1'b0;
        if (FLUSH) begin
            w_next_state = EMPTY;
        end else begin
            case (r_state)
                EMPTY: begin
                    if (w_in_xfer) begin
                        w_next_state   = ONE;
                        w_load_main_in = 1'b1;
                    end
                end
                ONE: begin
                    if (w_in_xfer && w_out_xfer) begin
                        w_load_main_in = 1'b1;
                    end else if (w_in_xfer && SKID) begin
                        w_next_state = TWO;
                        w_load_skid  = 1'b1;
                    end else if (w_out_xfer) begin
                        w_next_state = EMPTY;
                    end
                end
                TWO: begin
                    if (w_out_xfer) begin
                        w_next_state     = ONE;
                        w_load_main_skid = 1'b1;
                    end
                end
                default: w_next_state = EMPTY;
            endcase
        end
    end

    // Outputs and transfer strobes.
    always_comb begin
        OUT_VALID = (r_state != EMPTY);
        OUT_CTRL  = OUT_VALID ? r_main_ctrl : CTRL_RST;
        OUT_DATA  = r_main_data;
        LEVEL     = level_of(r_state);
        if (SKID) begin
            IN_READY = r_in_ready && !FLUSH && RESET_N;
        end else begin
            IN_READY = (!OUT_VALID || OUT_READY) && !FLUSH && RESET_N;
        end
        w_in_xfer  = IN_VALID && IN_READY;
        w_out_xfer = OUT_VALID && OUT_READY;
    end

    // Entry storage: control and data of one transfer always move together.
    always_ff @(posedge CLK) begin
        if (!RESET_N) begin
            r_main_ctrl <= CTRL_RST;
            r_main_data <= '0;
            r_skid_ctrl <= CTRL_RST;
            r_skid_data <= '0;
        end else if (FLUSH) begin
            r_main_ctrl <= CTRL_RST;
        end else begin
            if (w_load_main_in) begin
                r_main_ctrl <= IN_CTRL;
                r_main_data <= IN_DATA;
            end else if (w_load_main_skid) begin
                r_main_ctrl <= r_skid_ctrl;
                r_main_data <= r_skid_data;
            end
            if (w_load_skid) begin
                r_skid_ctrl <= IN_CTRL;
                r_skid_data <= IN_DATA;
            end
        end
    end

endmodule

// File: tb/tb_pipe_stage_reg.sv
// tb/tb_pipe_stage_reg.sv - scoreboard bench for pipe_stage_reg in skid and single-entry modes

module tb_pipe_stage_reg;

    localparam int DW = 96;
    localparam int CW = 9;
    localparam logic [CW-1:0] RST0 = 9'h000;
    localparam logic [CW-1:0] RST1 = 9'h0A5;

    typedef struct packed {
        logic [CW-1:0] c;
        logic [DW-1:0] d;
    } item_t;

    logic          clk = 1'b0;
    logic          resetn;
    logic          flush;
    logic          in_valid;
    logic [CW-1:0] in_ctrl;
    logic [DW-1:0] in_data;
    logic          out_ready;

    logic          in_ready  [2];
    logic          out_valid [2];
    logic [CW-1:0] out_ctrl  [2];
    logic [DW-1:0] out_data  [2];
    logic [1:0]    level     [2];

    int n_cmp = 0;
    int n_bad = 0;
    bit mon_on = 1'b0;

    item_t sbq [2][$];
    bit    mrdy [2];

    always #5 clk = ~clk;

    pipe_stage_reg #(.DATA_W(DW), .CTRL_W(CW), .CTRL_RST(RST0), .SKID(1'b1)) u_skid (
        .CLK(clk), .RESET_N(resetn), .FLUSH(flush),
        .IN_VALID(in_valid), .IN_READY(in_ready[0]), .IN_CTRL(in_ctrl), .IN_DATA(in_data),
        .OUT_VALID(out_valid[0]), .OUT_READY(out_ready), .OUT_CTRL(out_ctrl[0]),
        .OUT_DATA(out_data[0]), .LEVEL(level[0])
    );

    pipe_stage_reg #(.DATA_W(DW), .CTRL_W(CW), .CTRL_RST(RST1), .SKID(1'b0)) u_single (
        .CLK(clk), .RESET_N(resetn), .FLUSH(flush),
        .IN_VALID(in_valid), .IN_READY(in_ready[1]), .IN_CTRL(in_ctrl), .IN_DATA(in_data),
        .OUT_VALID(out_valid[1]), .OUT_READY(out_ready), .OUT_CTRL(out_ctrl[1]),
        .OUT_DATA(out_data[1]), .LEVEL(level[1])
    );

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: an ordered list of accepted transfers per instance.
    // Capacity is 2 (skid) or 1 (single); ready is the capacity rule.
    always @(negedge clk) begin
        if (mon_on) begin
            for (int k = 0; k < 2; k++) begin
                int            cnt;
                bit            exp_v;
                bit            exp_ir;
                logic [CW-1:0] rstc;
                string         tag;
                tag  = (k == 0) ? "skid" : "single";
                rstc = (k == 0) ? RST0 : RST1;
                cnt  = sbq[k].size();
                exp_v = (cnt > 0);
                if (!resetn || flush)
                    exp_ir = 1'b0;
                else if (k == 0)
                    exp_ir = mrdy[k];
                else
                    exp_ir = (cnt == 0) || out_ready;

                chk({tag, ".in_ready"}, 128'(in_ready[k]), 128'(exp_ir));
                chk({tag, ".out_valid"}, 128'(out_valid[k]), 128'(exp_v));
                chk({tag, ".level"}, 128'(level[k]), 128'(cnt));
                if (exp_v) begin
                    chk({tag, ".out_ctrl"}, 128'(out_ctrl[k]), 128'(sbq[k][0].c));
                    chk({tag, ".out_data"}, 128'(out_data[k]), 128'(sbq[k][0].d));
                end else begin
                    chk({tag, ".bubble_ctrl"}, 128'(out_ctrl[k]), 128'(rstc));
                end

                if (!resetn) begin
                    sbq[k].delete();
                    mrdy[k] = 1'b0;
                end else begin
                    if (exp_v && out_ready) void'(sbq[k].pop_front());
                    if (flush) sbq[k].delete();
                    else if (in_valid && exp_ir) sbq[k].push_back('{c: in_ctrl, d: in_data});
                    mrdy[k] = (sbq[k].size() < 2);
                end
            end
        end
    end

    task automatic drive(input bit v, input logic [CW-1:0] c, input logic [DW-1:0] d,
                         input bit ordy, input bit fl);
        in_valid  = v;
        in_ctrl   = c;
        in_data   = d;
        out_ready = ordy;
        flush     = fl;
        @(posedge clk);
        #1;
    endtask

    function automatic logic [DW-1:0] rnd_data();
        return {$urandom(), $urandom(), $urandom()};
    endfunction

    initial begin
        resetn    = 1'b0;
        flush     = 1'b0;
        in_valid  = 1'b1;
        in_ctrl   = '1;
        in_data   = 96'h55;
        out_ready = 1'b1;
        mrdy[0]   = 1'b0;
        mrdy[1]   = 1'b0;

        // Reset held two cycles with IN_VALID asserted.
        @(posedge clk);
        #1;
        mon_on = 1'b1;
        @(posedge clk);
        #1;
        chk("reset.skid.out_data", 128'(out_data[0]), 128'(0));
        chk("reset.single.out_data", 128'(out_data[1]), 128'(0));
        resetn = 1'b1;
        drive(1'b0, '0, '0, 1'b1, 1'b0);

        // Streaming 0x10..0x17.
        for (int i = 0; i < 8; i++) drive(1'b1, CW'(i + 1), DW'(8'h10 + i), 1'b1, 1'b0);
        drive(1'b0, '0, '0, 1'b1, 1'b0);
        drive(1'b0, '0, '0, 1'b1, 1'b0);

        // Backpressure: 0x20, 0x21 then stall three cycles, then release.
        drive(1'b1, 9'h101, 96'h20, 1'b0, 1'b0);
        drive(1'b1, 9'h102, 96'h21, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) drive(1'b0, '0, '0, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) drive(1'b0, '0, '0, 1'b1, 1'b0);

        // Flush with two held entries and a competing input 0x30.
        drive(1'b1, 9'h1F0, 96'h28, 1'b0, 1'b0);
        drive(1'b1, 9'h1F1, 96'h29, 1'b0, 1'b0);
        drive(1'b1, 9'h1FF, 96'h30, 1'b1, 1'b1);
        drive(1'b0, '0, '0, 1'b1, 1'b0);

        // Bubbles with all-ones control on the input.
        for (int i = 0; i < 4; i++) drive(1'b0, '1, rnd_data(), i[0], 1'b0);

        // Single-entry ready following OUT_READY.
        for (int i = 0; i < 8; i++) drive(1'b1, CW'(i), DW'(8'h40 + i), !i[0], 1'b0);
        drive(1'b0, '0, '0, 1'b1, 1'b0);
        drive(1'b0, '0, '0, 1'b1, 1'b0);

        // Randomized traffic with occasional flush and reset.
        for (int i = 0; i < 600; i++) begin
            resetn = ($urandom_range(0, 199) != 0);
            drive(($urandom_range(0, 3) != 0), CW'($urandom()), rnd_data(),
                  ($urandom_range(0, 2) != 0), ($urandom_range(0, 31) == 0));
        end
        resetn = 1'b1;
        for (int i = 0; i < 4; i++) drive(1'b0, '0, '0, 1'b1, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
